// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared pipeline definitions: opcode/aluop encodings, instruction field
// positions, the sequencer state encoding and small decode helpers.
package pipeline_pkg;

    // Opcode encodings, ir[31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    // R-type aluop encodings, ir[6:2]
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Instruction field slice positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int ALU_MSB = 6;
    localparam int ALU_LSB = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_BUSY = 2'b01,
        ST_MD_DONE = 2'b10
    } seq_state_t;

    // Stores and compare-branches read the rd field as a source operand.
    function automatic logic reads_rd(input logic [4:0] opcode);
        return (opcode == OP_SW) || (opcode == OP_BNE) || (opcode == OP_BLT);
    endfunction

    // mul/div are R-type instructions distinguished by aluop.
    function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_ir_field_decode.sv
// Instruction field decoder used for both the FD and DE latch contents.
//  ir          in  32  instruction word
//  opcode      out 5   ir[31:27]
//  rd/rs/rt    out 5   register fields
//  is_lw       out 1   instruction is a load
//  is_md       out 1   instruction is mul or div
//  src_uses_rd out 1   instruction reads rd as a source (sw/bne/blt)
module ir_field_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        is_lw,
    output logic        is_md,
    output logic        src_uses_rd
);

    logic [4:0] aluop_s;
    logic       ir_unused_s;

    assign opcode      = ir[OPC_MSB:OPC_LSB];
    assign rd          = ir[RD_MSB:RD_LSB];
    assign rs          = ir[RS_MSB:RS_LSB];
    assign rt          = ir[RT_MSB:RT_LSB];
    assign aluop_s     = ir[ALU_MSB:ALU_LSB];
    assign is_lw       = (opcode == OP_LW);
    assign is_md       = is_multdiv(opcode, aluop_s);
    assign src_uses_rd = reads_rd(opcode);

    // Shamt and the low two bits play no part in hazard detection.
    assign ir_unused_s = ^{ir[11:7], ir[1:0]};

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/bubble sequencer for the 5-stage pipeline, including the
// multdiv start/ready handshake with watchdog and a saturating stall counter.
//  clock, reset (async, active-low)
//  fd_ir, de_ir             instruction words in FD and DE latches
//  branch_taken, jump_taken control-flow redirects
//  md_ready, md_exception   multdiv completion handshake
//  pc_we, fd_we, de_we      latch write enables
//  fd_flush, de_bubble, em_bubble, md_start, md_result_sel  pipeline controls
//  md_timeout               sticky watchdog flag
//  stall_cycles             saturating count of cycles with pc_we=0
module pipeline_hazard_sequencer #(
    parameter int MD_TIMEOUT  = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            fd_ir,
    input  logic [31:0]            de_ir,
    input  logic                   branch_taken,
    input  logic                   jump_taken,
    input  logic                   md_ready,
    input  logic                   md_exception,
    output logic                   pc_we,
    output logic                   fd_we,
    output logic                   de_we,
    output logic                   fd_flush,
    output logic                   de_bubble,
    output logic                   em_bubble,
    output logic                   md_start,
    output logic                   md_result_sel,
    output logic                   md_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    import pipeline_pkg::*;

    localparam int TMR_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic [4:0] fd_opcode_s, fd_rd_s, fd_rs_s, fd_rt_s;
    logic [4:0] de_opcode_s, de_rd_s, de_rs_s, de_rt_s;
    logic       fd_is_lw_s, fd_is_md_s, fd_uses_rd_s;
    logic       de_is_lw_s, de_is_md_s, de_uses_rd_s;
    logic       decode_unused_s;

    seq_state_t             state_r, next_state_s;
    logic [TMR_W-1:0]       timer_r;
    logic                   md_timeout_r;
    logic [STALL_CNT_W-1:0] stall_cycles_r;
    logic                   arm_r;
    logic                   load_use_s, timeout_set_s;
    logic pc_we_s, fd_we_s, de_we_s, fd_flush_s, de_bubble_s, em_bubble_s, md_start_s, md_sel_s;

    ir_field_decode u_fd_dec (
        .ir(fd_ir), .opcode(fd_opcode_s), .rd(fd_rd_s), .rs(fd_rs_s), .rt(fd_rt_s),
        .is_lw(fd_is_lw_s), .is_md(fd_is_md_s), .src_uses_rd(fd_uses_rd_s)
    );

    ir_field_decode u_de_dec (
        .ir(de_ir), .opcode(de_opcode_s), .rd(de_rd_s), .rs(de_rs_s), .rt(de_rt_s),
        .is_lw(de_is_lw_s), .is_md(de_is_md_s), .src_uses_rd(de_uses_rd_s)
    );

    // Exceptions are written back downstream; the remaining decode outputs
    // are not needed for the stage each decoder serves.
    assign decode_unused_s = ^{md_exception, fd_opcode_s, fd_is_lw_s, fd_is_md_s,
                               de_opcode_s, de_rs_s, de_rt_s, de_uses_rd_s};

    // r0 is never a real destination, so a load into it never stalls.
    assign load_use_s = de_is_lw_s && (de_rd_s != 5'd0) &&
                        ((de_rd_s == fd_rs_s) || (de_rd_s == fd_rt_s) ||
                         (fd_uses_rd_s && (de_rd_s == fd_rd_s)));

    // Next-state and pipeline control decode; reset forces no-hazard values.
    always_comb begin
        next_state_s  = state_r;
        timeout_set_s = 1'b0;
        pc_we_s       = 1'b1;
        fd_we_s       = 1'b1;
        de_we_s       = 1'b1;
        fd_flush_s    = 1'b0;
        de_bubble_s   = 1'b0;
        em_bubble_s   = 1'b0;
        md_start_s    = 1'b0;
        md_sel_s      = 1'b0;
        if (reset) begin
            case (state_r)
                ST_RUN: begin
                    // arm_r keeps a stale mul/div left in DE across reset from restarting.
                    if (arm_r && de_is_md_s) begin
                        pc_we_s      = 1'b0;
                        fd_we_s      = 1'b0;
                        de_we_s      = 1'b0;
                        em_bubble_s  = 1'b1;
                        md_start_s   = 1'b1;
                        next_state_s = ST_MD_BUSY;
                    end else if (jump_taken) begin
                        fd_flush_s  = 1'b1;
                        de_bubble_s = 1'b1;
                    end else if (branch_taken) begin
                        fd_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_we_s     = 1'b0;
                        fd_we_s     = 1'b0;
                        de_bubble_s = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    pc_we_s     = 1'b0;
                    fd_we_s     = 1'b0;
                    de_we_s     = 1'b0;
                    em_bubble_s = 1'b1;
                    if (md_ready) begin
                        next_state_s = ST_MD_DONE;
                    end else if (timer_r == TMR_LIMIT) begin
                        timeout_set_s = 1'b1;
                        next_state_s  = ST_MD_DONE;
                    end else begin
                        next_state_s = ST_MD_BUSY;
                    end
                end
                ST_MD_DONE: begin
                    // A redirect frozen during the multdiv resolves now.
                    md_sel_s     = 1'b1;
                    next_state_s = ST_RUN;
                    if (jump_taken) begin
                        fd_flush_s  = 1'b1;
                        de_bubble_s = 1'b1;
                    end else if (branch_taken) begin
                        fd_flush_s = 1'b1;
                    end else begin
                        fd_flush_s = 1'b0;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                end
            endcase
        end else begin
            next_state_s = ST_RUN;
        end
    end

    // State, watchdog timer, sticky timeout, stall counter and DE-reload arm flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_RUN;
            timer_r        <= TMR_ONE;
            md_timeout_r   <= 1'b0;
            stall_cycles_r <= {STALL_CNT_W{1'b0}};
            arm_r          <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_MD_BUSY) begin
                timer_r <= timer_r + TMR_ONE;
            end else begin
                timer_r <= TMR_ONE;
            end
            if (timeout_set_s) begin
                md_timeout_r <= 1'b1;
            end else begin
                md_timeout_r <= md_timeout_r;
            end
            if (!pc_we_s && (stall_cycles_r != {STALL_CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (de_we_s) begin
                arm_r <= 1'b1;
            end else begin
                arm_r <= arm_r;
            end
        end
    end

    assign pc_we         = pc_we_s;
    assign fd_we         = fd_we_s;
    assign de_we         = de_we_s;
    assign fd_flush      = fd_flush_s;
    assign de_bubble     = de_bubble_s;
    assign em_bubble     = em_bubble_s;
    assign md_start      = md_start_s;
    assign md_result_sel = md_sel_s;
    assign md_timeout    = md_timeout_r;
    assign stall_cycles  = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: directed scenarios plus a randomized
// run against a cycle-level reference model. Two instances share stimulus;
// the second has a 2-bit stall counter to exercise saturation.
module tb_pipeline_hazard_sequencer;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fd_ir = 32'd0;
    logic [31:0] de_ir = 32'd0;
    logic        branch_taken = 1'b0, jump_taken = 1'b0, md_ready = 1'b0, md_exception = 1'b0;

    logic pc_we_a, fd_we_a, de_we_a, fd_flush_a, de_bubble_a, em_bubble_a, md_start_a, md_sel_a, md_to_a;
    logic pc_we_b, fd_we_b, de_we_b, fd_flush_b, de_bubble_b, em_bubble_b, md_start_b, md_sel_b, md_to_b;
    logic [15:0] stall_a;
    logic [1:0]  stall_b;
    logic [7:0]  obs_a;

    assign obs_a = {pc_we_a, fd_we_a, de_we_a, fd_flush_a, de_bubble_a, em_bubble_a, md_start_a, md_sel_a};

    pipeline_hazard_sequencer #(.MD_TIMEOUT(TO), .STALL_CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .de_ir(de_ir),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .md_ready(md_ready),
        .md_exception(md_exception), .pc_we(pc_we_a), .fd_we(fd_we_a), .de_we(de_we_a),
        .fd_flush(fd_flush_a), .de_bubble(de_bubble_a), .em_bubble(em_bubble_a),
        .md_start(md_start_a), .md_result_sel(md_sel_a), .md_timeout(md_to_a),
        .stall_cycles(stall_a)
    );

    pipeline_hazard_sequencer #(.MD_TIMEOUT(TO), .STALL_CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .de_ir(de_ir),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .md_ready(md_ready),
        .md_exception(md_exception), .pc_we(pc_we_b), .fd_we(fd_we_b), .de_we(de_we_b),
        .fd_flush(fd_flush_b), .de_bubble(de_bubble_b), .em_bubble(em_bubble_b),
        .md_start(md_start_b), .md_result_sel(md_sel_b), .md_timeout(md_to_b),
        .stall_cycles(stall_b)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state: busy cycle index (0 = not busy), done cycle,
    // DE reloaded since reset, sticky timeout, total stall cycles.
    int m_busy   = 0;
    bit m_done   = 1'b0;
    bit m_armed  = 1'b0;
    bit m_to     = 1'b0;
    int m_stalls = 0;

    function automatic logic [31:0] mk_r(input int rd, input int rs, input int rt, input int aluop);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(aluop), 2'd0};
    endfunction

    function automatic logic [31:0] mk_i(input int op, input int rd, input int rs, input logic [16:0] imm);
        return {5'(op), 5'(rd), 5'(rs), imm};
    endfunction

    function automatic bit f_is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
    endfunction

    function automatic bit f_load_use(input logic [31:0] de, input logic [31:0] fd);
        logic [4:0] rd;
        bit reads_rd;
        rd = de[26:22];
        reads_rd = (fd[31:27] == 5'd7) || (fd[31:27] == 5'd2) || (fd[31:27] == 5'd6);
        return (de[31:27] == 5'd8) && (rd != 5'd0) &&
               ((rd == fd[21:17]) || (rd == fd[16:12]) || (reads_rd && (rd == fd[26:22])));
    endfunction

    // Expected {pc_we, fd_we, de_we, fd_flush, de_bubble, em_bubble, md_start, md_result_sel}
    function automatic logic [7:0] exp_comb();
        logic [7:0] e;
        e = 8'b1110_0000;
        if (!reset) return e;
        if (m_busy > 0) begin
            e = 8'b0000_0100;
        end else if (m_done) begin
            e[0] = 1'b1;
            if (jump_taken) e[4:3] = 2'b11;
            else if (branch_taken) e[4] = 1'b1;
        end else if (m_armed && f_is_md(de_ir)) begin
            e = 8'b0000_0110;
        end else if (jump_taken) begin
            e[4:3] = 2'b11;
        end else if (branch_taken) begin
            e[4] = 1'b1;
        end else if (f_load_use(de_ir, fd_ir)) begin
            e[7] = 1'b0;
            e[6] = 1'b0;
            e[3] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [15:0] exp_stall_a();
        return (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    endfunction

    function automatic logic [1:0] exp_stall_b();
        return (m_stalls > 3) ? 2'd3 : 2'(m_stalls);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 1'b0; m_armed = 1'b0; m_to = 1'b0; m_stalls = 0;
    endtask

    task automatic model_advance(input logic [7:0] e);
        if (!reset) return;
        if (!e[7]) m_stalls++;
        if (e[5]) m_armed = 1'b1;
        if (m_busy > 0) begin
            if (md_ready) begin
                m_busy = 0; m_done = 1'b1;
            end else if (m_busy == TO) begin
                m_busy = 0; m_done = 1'b1; m_to = 1'b1;
            end else begin
                m_busy++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (e[1]) begin
            m_busy = 1;
        end
    endtask

    task automatic drive(input logic [31:0] fd, input logic [31:0] de, input bit br, input bit jp, input bit rdy);
        fd_ir = fd; de_ir = de; branch_taken = br; jump_taken = jp; md_ready = rdy;
        #1;
    endtask

    task automatic tick();
        logic [7:0] e;
        e = exp_comb();
        @(posedge clock);
        model_advance(e);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    logic [31:0] NOP, LW_R3, ADD_R4_R3, MUL_1, DIV_1, BNE_1;
    initial begin
        NOP       = 32'd0;
        LW_R3     = mk_i(8, 3, 1, 17'd4);
        ADD_R4_R3 = mk_r(4, 3, 5, 0);
        MUL_1     = mk_r(6, 1, 2, 6);
        DIV_1     = mk_r(6, 1, 2, 7);
        BNE_1     = mk_i(2, 9, 10, 17'd3);
    end

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        drive(ADD_R4_R3, MUL_1, 1'b1, 1'b0, 1'b0);
        model_reset();
        checks++;
        if (obs_a !== 8'b1110_0000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs_a, 8'b1110_0000); end
        checks++;
        if (stall_a !== 16'd0 || md_to_a !== 1'b0) begin errors++; $display("FAIL reset_regs: stall=%0d to=%b expected 0 0", stall_a, md_to_a); end
        @(negedge clock);
        reset = 1'b1;
        // A mul left in DE over reset must not start.
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000) begin errors++; $display("FAIL stale_md_after_reset: got %b expected %b", obs_a, 8'b1110_0000); end
        tick();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_load_use();
        int base;
        base = m_stalls;
        drive(ADD_R4_R3, LW_R3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b0010_1000) begin errors++; $display("FAIL load_use_rs: got %b expected %b", obs_a, 8'b0010_1000); end
        tick();
        drive(ADD_R4_R3, NOP, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000 || stall_a !== 16'(base + 1)) begin
            errors++; $display("FAIL load_use_release: got %b stall=%0d expected %b stall=%0d", obs_a, stall_a, 8'b1110_0000, base + 1);
        end
        tick();
        // sw reads rd as a source
        drive(mk_i(7, 7, 2, 17'd0), mk_i(8, 7, 1, 17'd0), 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b0010_1000) begin errors++; $display("FAIL load_use_sw_rd: got %b expected %b", obs_a, 8'b0010_1000); end
        tick();
        // R-type rd is a destination, not a source
        drive(mk_r(7, 1, 2, 0), mk_i(8, 7, 1, 17'd0), 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000) begin errors++; $display("FAIL load_use_dest_only: got %b expected %b", obs_a, 8'b1110_0000); end
        tick();
    endtask

    task automatic test_r0();
        drive(mk_r(4, 0, 0, 0), mk_i(8, 0, 1, 17'd0), 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000) begin errors++; $display("FAIL r0_no_hazard: got %b expected %b", obs_a, 8'b1110_0000); end
        tick();
    endtask

    task automatic test_mul();
        int base;
        base = m_stalls;
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b0000_0110) begin errors++; $display("FAIL mul_start: got %b expected %b", obs_a, 8'b0000_0110); end
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, (i == 5));
            checks++;
            if (obs_a !== 8'b0000_0100) begin errors++; $display("FAIL mul_busy%0d: got %b expected %b", i, obs_a, 8'b0000_0100); end
            tick();
        end
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0001) begin errors++; $display("FAIL mul_done: got %b expected %b", obs_a, 8'b1110_0001); end
        tick();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000 || stall_a !== 16'(base + 6)) begin
            errors++; $display("FAIL mul_stall_count: got %b stall=%0d expected %b stall=%0d", obs_a, stall_a, 8'b1110_0000, base + 6);
        end
        tick();
    endtask

    task automatic test_jump_branch();
        drive(ADD_R4_R3, LW_R3, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_a !== 8'b1111_1000) begin errors++; $display("FAIL jump_and_branch: got %b expected %b", obs_a, 8'b1111_1000); end
        tick();
        drive(ADD_R4_R3, LW_R3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1111_0000) begin errors++; $display("FAIL branch_over_load_use: got %b expected %b", obs_a, 8'b1111_0000); end
        tick();
    endtask

    task automatic test_held_branch();
        drive(BNE_1, MUL_1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b0000_0110) begin errors++; $display("FAIL held_start: got %b expected %b", obs_a, 8'b0000_0110); end
        tick();
        drive(BNE_1, MUL_1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_a !== 8'b0000_0100) begin errors++; $display("FAIL held_busy: got %b expected %b", obs_a, 8'b0000_0100); end
        tick();
        drive(BNE_1, MUL_1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1111_0001) begin errors++; $display("FAIL held_resolve: got %b expected %b", obs_a, 8'b1111_0001); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(MUL_1, MUL_1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(MUL_1, MUL_1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0001) begin errors++; $display("FAIL b2b_done_no_restart: got %b expected %b", obs_a, 8'b1110_0001); end
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b0000_0110) begin errors++; $display("FAIL b2b_second_start: got %b expected %b", obs_a, 8'b0000_0110); end
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(NOP, MUL_1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_spurious_ready();
        for (int i = 0; i < 2; i++) begin
            drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_a !== 8'b1110_0000) begin errors++; $display("FAIL spurious_ready%0d: got %b expected %b", i, obs_a, 8'b1110_0000); end
            tick();
        end
    endtask

    task automatic test_timeout();
        drive(NOP, DIV_1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= TO; i++) begin
            drive(NOP, DIV_1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_a !== 8'b0000_0100 || md_to_a !== 1'b0) begin
                errors++; $display("FAIL timeout_busy%0d: got %b to=%b expected %b to=0", i, obs_a, md_to_a, 8'b0000_0100);
            end
            tick();
        end
        drive(NOP, DIV_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0001 || md_to_a !== 1'b1 || md_to_b !== 1'b1) begin
            errors++; $display("FAIL timeout_done: got %b to=%b expected %b to=1", obs_a, md_to_a, 8'b1110_0001);
        end
        tick();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000 || md_to_a !== 1'b1) begin
            errors++; $display("FAIL timeout_run_resume: got %b to=%b expected %b to=1", obs_a, md_to_a, 8'b1110_0000);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_a !== 8'b1110_0000 || stall_a !== 16'd0 || md_to_a !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy: got %b stall=%0d to=%b expected %b stall=0 to=0", obs_a, stall_a, md_to_a, 8'b1110_0000);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b1110_0000) begin errors++; $display("FAIL no_reissue: got %b expected %b", obs_a, 8'b1110_0000); end
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 8'b0000_0110) begin errors++; $display("FAIL new_md_starts: got %b expected %b", obs_a, 8'b0000_0110); end
        tick();
        drive(ADD_R4_R3, MUL_1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(NOP, MUL_1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(ADD_R4_R3, LW_R3, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_b !== 2'd3 || stall_a !== 16'd5) begin
            errors++; $display("FAIL stall_saturate: got b=%0d a=%0d expected b=3 a=5", stall_b, stall_a);
        end
        tick();
    endtask

    function automatic logic [31:0] rand_ir(input bit allow_md);
        int k;
        int rd, rs, rt;
        k  = $urandom_range(allow_md ? 0 : 2, 9);
        rd = $urandom_range(0, 7);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        case (k)
            0, 1:    return mk_r(rd, rs, rt, $urandom_range(6, 7));
            2, 3:    return mk_i(8, rd, rs, {5'(rt), 12'($urandom)});
            4:       return mk_i(7, rd, rs, {5'(rt), 12'($urandom)});
            5:       return mk_i(2, rd, rs, {5'(rt), 12'($urandom)});
            6:       return mk_i(6, rd, rs, {5'(rt), 12'($urandom)});
            7:       return mk_r(rd, rs, rt, 0);
            8:       return mk_i(5, rd, rs, {5'(rt), 12'($urandom)});
            default: return mk_i(1, 0, 0, 17'($urandom));
        endcase
    endfunction

    task automatic test_random();
        logic [7:0] e;
        logic [31:0] fd_hold, de_hold;
        fd_hold = NOP;
        de_hold = NOP;
        for (int n = 0; n < 800; n++) begin
            // The pipeline holds latch contents while the multdiv is in flight.
            if (m_busy == 0) begin
                fd_hold = rand_ir(1'b1);
                de_hold = rand_ir(1'b1);
            end
            md_exception = 1'($urandom);
            drive(fd_hold, de_hold, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0));
            e = exp_comb();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL rand_ctrl@%0d: got %b expected %b", n, obs_a, e); end
            checks++;
            if (stall_a !== exp_stall_a() || stall_b !== exp_stall_b()) begin
                errors++; $display("FAIL rand_stall@%0d: got a=%0d b=%0d expected a=%0d b=%0d", n, stall_a, stall_b, exp_stall_a(), exp_stall_b());
            end
            checks++;
            if (md_to_a !== m_to || md_to_b !== m_to) begin
                errors++; $display("FAIL rand_timeout@%0d: got a=%b b=%b expected %b", n, md_to_a, md_to_b, m_to);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_mul();
        test_jump_branch();
        test_held_branch();
        test_back_to_back();
        test_spurious_ready();
        test_timeout();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
